// File: rtl/tournament_update_ctrl.sv
// Training/recovery controller for the tournament predictor: table init sweep, in-flight queue, update sequencing.
// Optional macro TOURN_STATS_EN adds saturating resolved/mispredict counters.
module tournament_update_ctrl #(
  parameter int GHR_W = 12,
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       pred_valid,
  output logic                       pred_ready,
  input  logic [PC_W-1:0]            pred_pc,
  input  logic [GHR_W-1:0]           pred_ghr,
  input  logic                       pred_local,
  input  logic                       pred_global,
  input  logic                       pred_taken,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic                       res_taken,
  output logic                       upd_valid,
  input  logic                       upd_ready,
  output logic [PC_W-1:0]            upd_pc,
  output logic [GHR_W-1:0]           upd_ghr,
  output logic                       upd_taken,
  output logic [1:0]                 upd_choice,
  output logic                       recover_valid,
  output logic [GHR_W-1:0]           recover_ghr,
  output logic                       init_valid,
  output logic [GHR_W-1:0]           init_index,
  output logic [$clog2(DEPTH):0]     occupancy,
`ifdef TOURN_STATS_EN
  output logic [31:0]                stat_resolved,
  output logic [31:0]                stat_mispred,
`endif
  output logic                       res_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [GHR_W-1:0] ghr;
    logic             loc;
    logic             glob;
    logic             taken;
  } entry_t;

  typedef enum logic [1:0] {INIT, RUN, UPD} state_t;

  state_t           state_q, state_d;
  logic [GHR_W-1:0] init_index_q, init_index_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
  logic [GHR_W-1:0] upd_ghr_q, upd_ghr_d;
  logic             upd_taken_q, upd_taken_d;
  logic [1:0]       upd_choice_q, upd_choice_d;
  logic             recover_valid_q, recover_valid_d;
  logic [GHR_W-1:0] recover_ghr_q, recover_ghr_d;
  logic             res_error_q, res_error_d;
  logic             push, pop, mispred;
  entry_t           head;
`ifdef TOURN_STATS_EN
  logic [31:0]      stat_resolved_q, stat_resolved_d;
  logic [31:0]      stat_mispred_q, stat_mispred_d;
`endif

  always_comb begin
    state_d         = state_q;
    init_index_d    = init_index_q;
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    upd_pc_d        = upd_pc_q;
    upd_ghr_d       = upd_ghr_q;
    upd_taken_d     = upd_taken_q;
    upd_choice_d    = upd_choice_q;
    recover_valid_d = 1'b0;
    recover_ghr_d   = recover_ghr_q;
    res_error_d     = res_error_q;
`ifdef TOURN_STATS_EN
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
`endif

    pred_ready = (state_q != INIT) && (count_q < CNT_W'(DEPTH));
    res_ready  = (state_q == RUN);
    head       = mem_q[rd_ptr_q];
    push       = pred_valid && pred_ready;
    pop        = res_valid && res_ready && (count_q != '0);
    mispred    = pop && (head.taken != res_taken);

    case (state_q)
      INIT: begin
        init_index_d = init_index_q + GHR_W'(1);
        if (init_index_q == '1) state_d = RUN;
      end
      RUN: begin
        if (res_valid && (count_q == '0)) res_error_d = 1'b1;
        if (pop) begin
          state_d      = UPD;
          upd_pc_d     = head.pc;
          upd_ghr_d    = head.ghr;
          upd_taken_d  = res_taken;
          upd_choice_d = 2'b00;
          if ((head.glob == res_taken) && (head.loc != res_taken)) upd_choice_d = 2'b01;
          if ((head.loc == res_taken) && (head.glob != res_taken)) upd_choice_d = 2'b10;
          if (mispred) begin
            recover_valid_d = 1'b1;
            recover_ghr_d   = {head.ghr[GHR_W-2:0], res_taken};
          end
`ifdef TOURN_STATS_EN
          if (stat_resolved_q != '1) stat_resolved_d = stat_resolved_q + 32'd1;
          if (mispred && (stat_mispred_q != '1)) stat_mispred_d = stat_mispred_q + 32'd1;
`endif
        end
      end
      UPD: begin
        if (upd_ready) state_d = RUN;
      end
      default: state_d = INIT;
    endcase

    // A mispredict squashes everything younger, including a push landing in the same cycle.
    if (mispred) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: pred_pc, ghr: pred_ghr, loc: pred_local,
                            glob: pred_global, taken: pred_taken};
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= INIT;
      init_index_q    <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      upd_pc_q        <= '0;
      upd_ghr_q       <= '0;
      upd_taken_q     <= 1'b0;
      upd_choice_q    <= 2'b00;
      recover_valid_q <= 1'b0;
      recover_ghr_q   <= '0;
      res_error_q     <= 1'b0;
`ifdef TOURN_STATS_EN
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
`endif
    end else begin
      state_q         <= state_d;
      init_index_q    <= init_index_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      upd_pc_q        <= upd_pc_d;
      upd_ghr_q       <= upd_ghr_d;
      upd_taken_q     <= upd_taken_d;
      upd_choice_q    <= upd_choice_d;
      recover_valid_q <= recover_valid_d;
      recover_ghr_q   <= recover_ghr_d;
      res_error_q     <= res_error_d;
`ifdef TOURN_STATS_EN
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
`endif
    end
  end

  // Queue storage needs no reset: occupancy gates every read.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign upd_valid     = (state_q == UPD);
  assign upd_pc        = upd_pc_q;
  assign upd_ghr       = upd_ghr_q;
  assign upd_taken     = upd_taken_q;
  assign upd_choice    = upd_choice_q;
  assign recover_valid = recover_valid_q;
  assign recover_ghr   = recover_ghr_q;
  assign init_valid    = (state_q == INIT);
  assign init_index    = init_index_q;
  assign occupancy     = count_q;
  assign res_error     = res_error_q;
`ifdef TOURN_STATS_EN
  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_tournament_update_ctrl.sv
// Self-checking bench for tournament_update_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_tournament_update_ctrl;

  localparam int GHR_W    = 12;
  localparam int DEPTH    = 8;
  localparam int PC_W     = 32;
  localparam int INIT_LEN = 1 << GHR_W;

  logic             clock = 1'b0;
  logic             reset;
  logic             pred_valid, pred_ready;
  logic [PC_W-1:0]  pred_pc;
  logic [GHR_W-1:0] pred_ghr;
  logic             pred_local, pred_global, pred_taken;
  logic             res_valid, res_ready, res_taken;
  logic             upd_valid, upd_ready;
  logic [PC_W-1:0]  upd_pc;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_taken;
  logic [1:0]       upd_choice;
  logic             recover_valid;
  logic [GHR_W-1:0] recover_ghr;
  logic             init_valid;
  logic [GHR_W-1:0] init_index;
  logic [$clog2(DEPTH):0] occupancy;
  logic             res_error;
`ifdef TOURN_STATS_EN
  logic [31:0]      stat_resolved, stat_mispred;
`endif

  tournament_update_ctrl #(.GHR_W(GHR_W), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_ghr(pred_ghr), .pred_local(pred_local), .pred_global(pred_global),
    .pred_taken(pred_taken),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_ghr(upd_ghr), .upd_taken(upd_taken), .upd_choice(upd_choice),
    .recover_valid(recover_valid), .recover_ghr(recover_ghr),
    .init_valid(init_valid), .init_index(init_index),
    .occupancy(occupancy),
`ifdef TOURN_STATS_EN
    .stat_resolved(stat_resolved), .stat_mispred(stat_mispred),
`endif
    .res_error(res_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [PC_W-1:0]  pc;
    logic [GHR_W-1:0] ghr;
    bit               loc;
    bit               glob;
    bit               tk;
  } pred_t;

  // Reference model: a plain queue plus a phase number (0 sweep, 1 idle, 2 training)
  pred_t            mq[$];
  int               mPhase;
  int               mInit;
  bit               mErr, mRecov, mUpdTaken;
  logic [GHR_W-1:0] mRecGhr, mUpdGhr;
  logic [PC_W-1:0]  mUpdPc;
  logic [1:0]       mUpdChoice;
  longint           mResolved, mMispred;

  int passCount  = 0;
  int checkCount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic checkModel();
    checkOutput("init_valid", 64'(init_valid), 64'(mPhase == 0));
    if (mPhase == 0) checkOutput("init_index", 64'(init_index), 64'(mInit));
    checkOutput("pred_ready", 64'(pred_ready), 64'((mPhase != 0) && (mq.size() < DEPTH)));
    checkOutput("res_ready", 64'(res_ready), 64'(mPhase == 1));
    checkOutput("upd_valid", 64'(upd_valid), 64'(mPhase == 2));
    checkOutput("occupancy", 64'(occupancy), 64'(mq.size()));
    checkOutput("res_error", 64'(res_error), 64'(mErr));
    checkOutput("recover_valid", 64'(recover_valid), 64'(mRecov));
    if (mRecov) checkOutput("recover_ghr", 64'(recover_ghr), 64'(mRecGhr));
    if (mPhase == 2) begin
      checkOutput("upd_pc", 64'(upd_pc), 64'(mUpdPc));
      checkOutput("upd_ghr", 64'(upd_ghr), 64'(mUpdGhr));
      checkOutput("upd_taken", 64'(upd_taken), 64'(mUpdTaken));
      checkOutput("upd_choice", 64'(upd_choice), 64'(mUpdChoice));
    end
`ifdef TOURN_STATS_EN
    checkOutput("stat_resolved", 64'(stat_resolved), 64'((mResolved > 64'hFFFFFFFF) ? 64'hFFFFFFFF : mResolved));
    checkOutput("stat_mispred", 64'(stat_mispred), 64'((mMispred > 64'hFFFFFFFF) ? 64'hFFFFFFFF : mMispred));
`endif
  endtask

  task automatic stepModel();
    pred_t e;
    bit    doPush;
    if (reset) begin
      mPhase = 0; mInit = 0; mq.delete(); mErr = 0; mRecov = 0;
      mResolved = 0; mMispred = 0;
      return;
    end
    if (mPhase == 0) begin
      mRecov = 0;
      if (mInit == INIT_LEN - 1) begin mPhase = 1; mInit = 0; end
      else mInit++;
      return;
    end
    doPush = pred_valid && (mq.size() < DEPTH);
    mRecov = 0;
    if (mPhase == 1 && res_valid) begin
      if (mq.size() == 0) mErr = 1;
      else begin
        e          = mq.pop_front();
        mUpdPc     = e.pc;
        mUpdGhr    = e.ghr;
        mUpdTaken  = res_taken;
        if (e.glob == res_taken && e.loc != res_taken) mUpdChoice = 2'b01;
        else if (e.loc == res_taken && e.glob != res_taken) mUpdChoice = 2'b10;
        else mUpdChoice = 2'b00;
        mResolved++;
        if (e.tk != res_taken) begin
          mMispred++;
          mRecov  = 1;
          mRecGhr = {e.ghr[GHR_W-2:0], res_taken};
          mq.delete();
          doPush  = 0;
        end
        mPhase = 2;
      end
    end else if (mPhase == 2 && upd_ready) begin
      mPhase = 1;
    end
    if (doPush) mq.push_back('{pred_pc, pred_ghr, pred_local, pred_global, pred_taken});
  endtask

  task automatic applyStimulus(input bit rst, input bit pv, input logic [PC_W-1:0] pc,
                               input logic [GHR_W-1:0] ghr, input bit loc, input bit glob,
                               input bit tk, input bit rv, input bit rt, input bit ur);
    reset = rst; pred_valid = pv; pred_pc = pc; pred_ghr = ghr;
    pred_local = loc; pred_global = glob; pred_taken = tk;
    res_valid = rv; res_taken = rt; upd_ready = ur;
    checkModel();
    @(posedge clock);
    stepModel();
    #1;
  endtask

  task automatic idle(input bit ur);
    applyStimulus(0, 0, '0, '0, 0, 0, 0, 0, 0, ur);
  endtask

  initial begin
    bit pv, rv, rt, ur;

    applyStimulus(1, 0, '0, '0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, '0, '0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_init_index", 64'(init_index), 64'd0);
    checkOutput("reset_upd_valid", 64'(upd_valid), 64'd0);
    repeat (INIT_LEN) idle(0);
    checkOutput("post_init_ready", 64'(pred_ready), 64'd1);
    checkOutput("post_init_occ", 64'(occupancy), 64'd0);

    // Fill the queue; head is the local-right/global-wrong correct entry.
    applyStimulus(0, 1, 32'h1000, 12'h011, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i < DEPTH; i++)
      applyStimulus(0, 1, 32'h1000 + 32'(i * 4), GHR_W'(i), 1'($urandom), 1'($urandom), 1, 0, 0, 0);
    checkOutput("full_ready", 64'(pred_ready), 64'd0);
    checkOutput("full_occ", 64'(occupancy), 64'd8);
    applyStimulus(0, 1, 32'h2000, '0, 0, 0, 1, 0, 0, 0);
    checkOutput("full_push_blocked", 64'(occupancy), 64'd8);

    applyStimulus(0, 1, 32'h2004, '0, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("held_upd_valid", 64'(upd_valid), 64'd1);
      checkOutput("held_choice", 64'(upd_choice), 64'h2);
      checkOutput("held_res_ready", 64'(res_ready), 64'd0);
      checkOutput("held_recover", 64'(recover_valid), 64'd0);
      idle(0);
    end
    idle(1);
    applyStimulus(0, 1, 32'h3000, 12'h123, 0, 1, 1, 1, 1, 0);
    checkOutput("pushpop_occ", 64'(occupancy), 64'd7);
    idle(1);

    // Flush what is left, then build a 4-deep queue whose head mispredicts.
    applyStimulus(0, 0, '0, '0, 0, 0, 0, 1, 0, 1);
    idle(1);
    applyStimulus(0, 1, 32'h4000, 12'hA5F, 1, 1, 1, 0, 0, 0);
    for (int i = 1; i < 4; i++)
      applyStimulus(0, 1, 32'h4000 + 32'(i * 4), 12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0);
    applyStimulus(0, 1, 32'h5000, 12'h777, 0, 0, 0, 1, 0, 0);
    checkOutput("mis_recover_valid", 64'(recover_valid), 64'd1);
    checkOutput("mis_recover_ghr", 64'(recover_ghr), 64'h4BE);
    checkOutput("mis_flush_occ", 64'(occupancy), 64'd0);
    idle(1);
    checkOutput("mis_pulse_once", 64'(recover_valid), 64'd0);

    applyStimulus(0, 0, '0, '0, 0, 0, 0, 1, 1, 0);
    checkOutput("empty_res_error", 64'(res_error), 64'd1);
    checkOutput("empty_res_occ", 64'(occupancy), 64'd0);
    repeat (3) idle(0);
    checkOutput("res_error_sticky", 64'(res_error), 64'd1);

    applyStimulus(0, 1, 32'h6000, 12'h0F0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, '0, '0, 0, 0, 0, 0, 0, 0);
    checkOutput("midupd_upd_valid", 64'(upd_valid), 64'd0);
    checkOutput("midupd_init_valid", 64'(init_valid), 64'd1);
    checkOutput("midupd_init_index", 64'(init_index), 64'd0);
    repeat (INIT_LEN) idle(0);

    for (int c = 0; c < 3000; c++) begin
      pv = ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 2) == 0);
      ur = ($urandom_range(0, 1) == 1);
      if (mq.size() > 0) rt = ($urandom_range(0, 5) == 0) ? ~mq[0].tk : mq[0].tk;
      else rt = 1'($urandom);
      applyStimulus(0, pv, 32'($urandom), 12'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), rv, rt, ur);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
